// File: rtl/miriscv_pkg.sv
// miriscv_pkg: constants and helpers shared by the miriscv fetch slice.
//   RESET_PC_DEFAULT : default address of the first fetch after reset
//   NOP_INSTR        : canonical RV32I NOP encoding (addi x0, x0, 0)
//   align_word()     : clears the byte-offset bits of an address
package miriscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/miriscv_fifo.sv
// miriscv_fifo: small synchronous FIFO used as the fetch instruction buffer.
// Ports:
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   flush_i        : empties the buffer; a same-cycle push or pop is ignored
//   push_i, data_i : write a word at the tail
//   pop_i          : remove the head word (ignored when empty)
//   valid_o        : head holds a word
//   data_o         : head word, forced to zero while empty
//   count_o        : number of stored words (0..DEPTH)
// A pushed word becomes visible on the following cycle; there is no bypass.
module miriscv_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == DEPTH_W);
  assign do_pop  = pop_i && (count_q != '0);
  // Push into a full buffer is accepted only when the head leaves this cycle.
  assign do_push = push_i && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: it is only observed through valid_o/data_o.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(push_i && full && !pop_i && !flush_i))
    else $error("miriscv_fifo: push into full buffer");

endmodule

// File: rtl/miriscv_fetch.sv
// miriscv_fetch: instruction fetch unit with an in-order request pipeline.
// Ports:
//   clk_i, arstn_i         : clock, asynchronous active-low reset
//   instr_req_o/addr_o     : fetch request and word-aligned address
//   instr_gnt_i            : request accepted this cycle
//   instr_rvalid_i/rdata_i : in-order read response
//   fetch_valid_o/instr_o  : buffer head instruction
//   fetch_pc_o             : address of the head instruction
//   fetch_ready_i          : core consumes head when valid&ready
//   redirect_i/redirect_pc_i : flush everything and restart fetch
// Requests are issued only while buffered + in-flight words fit the buffer,
// so a response always has room. After a redirect, responses still in
// flight are counted off in discard_q and dropped.
module miriscv_fetch
  import miriscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   addr_q, addr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] buf_count;
  logic          buf_valid;
  logic [CW:0]   inflight;
  logic          grant, push, pop, drop;

  // Extra bit so the sum cannot wrap even if an invariant were broken.
  assign inflight = {1'b0, buf_count} + {1'b0, outstanding_q};

  // Gated by reset so no request escapes while arstn_i is low, yet the
  // first cycle after release already requests.
  assign instr_req_o  = arstn_i && (inflight < DEPTH_W);
  assign instr_addr_o = addr_q;

  assign grant = instr_req_o && instr_gnt_i;
  assign drop  = instr_rvalid_i && (redirect_i || (discard_q != '0));
  assign push  = instr_rvalid_i && !drop;
  assign pop   = buf_valid && fetch_ready_i && !redirect_i;

  always_comb begin
    addr_d        = addr_q;
    head_pc_d     = head_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(instr_rvalid_i);
    discard_d     = discard_q;

    if (grant) addr_d = addr_q + 32'd4;
    if (pop)   head_pc_d = head_pc_q + 32'd4;
    if (instr_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;

    // Everything still in flight after this cycle, including a request
    // granted right now, belongs to the abandoned stream.
    if (redirect_i) begin
      addr_d    = align_word(redirect_pc_i);
      head_pc_d = align_word(redirect_pc_i);
      discard_d = outstanding_d;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      addr_q        <= RESET_PC;
      head_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      addr_q        <= addr_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  miriscv_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (instr_rdata_i),
    .pop_i   (pop),
    .valid_o (buf_valid),
    .data_o  (fetch_instr_o),
    .count_o (buf_count)
  );

  assign fetch_valid_o = buf_valid;
  assign fetch_pc_o    = head_pc_q;

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(instr_rvalid_i && (outstanding_q == '0)))
    else $error("miriscv_fetch: rvalid with nothing outstanding");

endmodule

// File: tb/tb_miriscv_fetch.sv
// tb_miriscv_fetch: directed stimulus with a memory model and an in-order
// scoreboard of expected (pc, instruction) pairs.
`timescale 1ns/1ps
module tb_miriscv_fetch;

  logic        clk = 1'b0;
  logic        arstn;
  logic        req, gnt, rvalid, valid, ready, redirect;
  logic [31:0] addr, rdata, instr, pc, redirect_pc;

  always #5 clk = ~clk;

  miriscv_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .instr_req_o    (req),
    .instr_addr_o   (addr),
    .instr_gnt_i    (gnt),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .fetch_valid_o  (valid),
    .fetch_instr_o  (instr),
    .fetch_pc_o     (pc),
    .fetch_ready_i  (ready),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_q[$];   // granted addresses awaiting a response
  logic [31:0] exp_q[$];   // addresses the core should still receive
  logic [31:0] sb_pc;
  bit          mem_stall = 1'b0;
  int          grants;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (valid) found = 1'b1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_pc"}, pc, exp_pc);
      chk({tag, "_instr"}, instr, mem_word(exp_pc));
    end
  endtask

  // Memory: responds in order, one cycle after grant, unless stalled.
  always @(posedge clk) begin
    #2;
    if (arstn && !mem_stall && mem_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = mem_word(mem_q[0]);
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  end

  // At each negedge, account for the handshakes of the coming posedge.
  always @(negedge clk) begin
    if (!arstn) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (valid && ready && !redirect) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_unexpected: observed pc %h expected no instruction", pc);
        end
        if (exp_q.size() != 0) begin
          sb_pc = exp_q.pop_front();
          chk("sb_pc", pc, sb_pc);
          chk("sb_instr", instr, mem_word(sb_pc));
        end
      end
      if (redirect)        exp_q.delete();
      else if (req && gnt) exp_q.push_back(addr);
      if (req && gnt)      mem_q.push_back(addr);
      if (rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0; gnt = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rvalid = 1'b0; rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(req),   32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr,      32'd0);
    chk("rst_pc",    pc,         32'd0);
    chk("rst_addr",  addr,       32'd0);

    // Release; grant withheld: request and address hold
    @(posedge clk); #1; arstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req",  32'(req), 32'd1);
      chk("stall_addr", addr,     32'd0);
    end

    // Full throughput
    @(posedge clk); #1; gnt = 1'b1; ready = 1'b1;
    @(negedge clk); chk("tp_addr0", addr, 32'd0);
    @(negedge clk); chk("tp_addr1", addr, 32'd4); chk("tp_valid_early", 32'(valid), 32'd0);
    @(negedge clk); chk("tp_valid", 32'(valid), 32'd1); chk("tp_pc0", pc, 32'd0);
    @(negedge clk); chk("tp_pc1", pc, 32'd4);
    @(negedge clk); chk("tp_pc2", pc, 32'd8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("tp_valid_hold", 32'(valid), 32'd1);
    end

    // Buffer fill with ready low
    @(posedge clk); #1; gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    @(posedge clk); #1; redirect = 1'b0;
    repeat (4) @(posedge clk);
    #1; ready = 1'b0; gnt = 1'b1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req) grants++;
    end
    chk("full_grants", 32'(grants), 32'd4);
    chk("full_req",    32'(req),    32'd0);
    chk("full_valid",  32'(valid),  32'd1);
    @(posedge clk); #1; ready = 1'b1;
    @(negedge clk); chk("drain_pc0", pc, 32'd0);
    @(negedge clk); chk("drain_pc1", pc, 32'd4);
    @(negedge clk); chk("drain_pc2", pc, 32'd8);
    @(negedge clk); chk("drain_pc3", pc, 32'd12);

    // Redirect with three requests outstanding
    @(posedge clk); #1; gnt = 1'b0;
    repeat (8) @(posedge clk);
    #1; mem_stall = 1'b1; gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1; gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1; redirect = 1'b0; gnt = 1'b1; mem_stall = 1'b0;
    @(negedge clk);
    chk("rd_addr",  addr,       32'h100);
    chk("rd_valid", 32'(valid), 32'd0);
    wait_valid("rd", 32'h100);

    // Redirect colliding with pop and response; unaligned target
    repeat (6) @(posedge clk);
    #1; redirect = 1'b1; redirect_pc = 32'h203;
    @(negedge clk); chk("rv_pre_valid", 32'(valid), 32'd1);
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk);
    chk("rv_flushed", 32'(valid), 32'd0);
    chk("rv_addr",    addr,       32'h200);
    chk("rv_headpc",  pc,         32'h200);
    wait_valid("rv", 32'h200);

    // Back-to-back redirects
    @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1; redirect_pc = 32'h400;
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk); chk("b2b_addr", addr, 32'h400);
    wait_valid("b2b", 32'h400);

    // Reset with two requests outstanding
    @(posedge clk); #1; gnt = 1'b0;
    repeat (8) @(posedge clk);
    #1; mem_stall = 1'b1; gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1; arstn = 1'b0;
    @(negedge clk);
    chk("rst2_req",   32'(req),   32'd0);
    chk("rst2_valid", 32'(valid), 32'd0);
    chk("rst2_instr", instr,      32'd0);
    chk("rst2_pc",    pc,         32'd0);
    chk("rst2_addr",  addr,       32'd0);
    @(posedge clk); #1; arstn = 1'b1; mem_stall = 1'b0;
    @(negedge clk);
    chk("rel_req",  32'(req), 32'd1);
    chk("rel_addr", addr,     32'd0);
    wait_valid("rel", 32'd0);

    repeat (5) @(posedge clk);
    #1; gnt = 1'b0;
    repeat (8) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/miriscv_fetch.md
MIRISCV_FETCH -- requirements
Module: miriscv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 4: instruction buffer entries and maximum outstanding requests; legal values are powers of 2, 2..16.
REQ-003 SHALL use one clock; reset is asynchronous and active-low (clk_i, arstn_i).
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 arstn_i  input  1  asynchronous active-low reset.
REQ-006 instr_req_o  output  1  fetch request to instruction memory.
REQ-007 instr_addr_o  output  32  word-aligned fetch address.
REQ-008 instr_gnt_i  input  1  request accepted this cycle.
REQ-009 instr_rvalid_i  input  1  read data valid; responses arrive in request order, at least 1 cycle after grant.
REQ-010 instr_rdata_i  input  32  instruction word.
REQ-011 fetch_valid_o  output  1  buffer head holds an instruction.
REQ-012 fetch_instr_o  output  32  head instruction.
REQ-013 fetch_pc_o  output  32  address of head instruction.
REQ-014 fetch_ready_i  input  1  core consumes head when valid&ready.
REQ-015 redirect_i  input  1  branch/jump/trap: discard everything, restart fetch.
REQ-016 redirect_pc_i  input  32  new fetch address; bits [1:0] forced to 0.

Function
REQ-017 Request: instr_req_o SHALL be 1 when buffer_count + outstanding < DEPTH; it SHALL NOT depend combinationally on redirect_i, fetch_ready_i or instr_rvalid_i.
REQ-018 instr_addr_o SHALL hold stable while instr_req_o=1 and instr_gnt_i=0.
REQ-019 On req&gnt, fetch address SHALL increment by 4 (wrapping at 2^32) and outstanding SHALL increment.
REQ-020 On rvalid, outstanding SHALL decrement; if discard_cnt>0, data SHALL be dropped and discard_cnt decremented, else instr_rdata_i SHALL be pushed into the buffer.
REQ-021 Buffer SHALL be FIFO; a pushed word SHALL appear on fetch_valid_o/fetch_instr_o the following cycle (1-cycle latency, no bypass).
REQ-022 fetch_pc_o SHALL equal head_pc, which increments by 4 on each pop (valid&ready) and loads redirect_pc_i on redirect.
REQ-023 Simultaneous push and pop SHALL be legal when full or empty-plus-push; count unchanged when both occur on a non-empty buffer.
REQ-024 Redirect cycle: buffer SHALL be flushed (fetch_valid_o=0 next cycle); a same-cycle pop SHALL be ignored; a same-cycle rvalid SHALL be dropped.
REQ-025 Redirect cycle: discard_cnt SHALL load outstanding after this cycle's grant and response (a request granted in the redirect cycle is also discarded).
REQ-026 Redirect cycle: fetch address SHALL load {redirect_pc_i[31:2],2'b00}; the first new request may issue the next cycle.
REQ-027 Back-to-back redirects SHALL be legal; each reloads discard_cnt per REQ-025.
REQ-028 Buffer overflow or rvalid with outstanding=0 SHALL be impossible under REQ-017/REQ-009; an assertion SHALL flag either.
REQ-029 At full throughput (gnt every cycle, rvalid 1 cycle later, ready=1), fetch_valid_o SHALL stay 1 every cycle.

Reset
REQ-030 During reset: instr_req_o=0, fetch_valid_o=0, buffer empty, outstanding=0, discard_cnt=0, fetch address and head_pc=RESET_PC, fetch_instr_o=0.
REQ-031 First cycle after arstn_i deasserts: instr_req_o=1, instr_addr_o=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL drop all state immediately; late rvalid after reset release with outstanding=0 is a memory-side protocol error.

Structure
REQ-033 Default RESET_PC and the NOP encoding 32'h0000_0013 SHALL live in shared package miriscv_pkg.
REQ-034 The buffer SHALL be sub-module miriscv_fifo (parametrised WIDTH, DEPTH, with flush input); counters stay in miriscv_fetch.
REQ-035 outstanding and discard_cnt SHALL be $clog2(DEPTH)+1 bits wide.

Verification
REQ-036 Reset release, gnt=1 always, rvalid 1 cycle later, ready=1 -> addresses 0,4,8,...; fetch_pc_o 0,4,8 on consecutive cycles from cycle 3.
REQ-037 ready=0 with DEPTH=4 -> exactly 4 grants, then instr_req_o=0; buffer holds 4 words; ready=1 -> pops in order with pc 0,4,8,12.
REQ-038 gnt held 0 for 5 cycles -> instr_addr_o stays 0 and instr_req_o stays 1.
REQ-039 3 outstanding, redirect to 32'h100 -> next 3 rvalids dropped; first delivered instruction has fetch_pc_o=32'h100 and data from 32'h100.
REQ-040 redirect_i with valid&ready and rvalid same cycle -> no pop counted, no push, fetch_valid_o=0 next cycle; redirect_pc_i=32'h203 -> fetch at 32'h200.
REQ-041 arstn_i low with 2 outstanding -> all outputs at REQ-030 values; restart fetch at RESET_PC.
